des_3des_sequencer: RTL and testbench

Sequences one shared, pipelined single-DES core through three passes to perform a 3DES (EDE) encryption or decryption of one 64-bit block. It sits between the block-level valid/ready stream and the DES datapath plus its round-key schedule. Each pass does three things: it presents the block, selects which of the three keys the schedule must expand and in which order, and captures the core result a fixed latency later. It accepts one block at a time and does not overlap blocks.

---
 rtl/des_3des_sequencer.sv | 150 +++++++++++++++
 tb/tb_des_3des_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_3des_sequencer.sv
// des_3des_sequencer: sequences one shared, pipelined single-DES core through
// three passes to perform a 3DES (EDE) encrypt or decrypt of one 64-bit block.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   in_valid/in_ready           block input handshake (in_ready = IDLE)
//   in_block, in_decrypt        input block and mode (0 = encrypt, 1 = decrypt)
//   core_block_in               registered block presented to the DES core
//   core_key_sel                key select for the schedule (0=K1, 1=K2, 2=K3)
//   core_key_decrypt            1 = schedule supplies round keys reversed
//   core_out                    DES core output, valid CORE_LATENCY edges later
//   out_valid/out_ready         result handshake
//   out_block                   3DES result
//   busy                        high in RUN or DONE
module des_3des_sequencer #(
  parameter int unsigned CORE_LATENCY = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] in_block,
  input  logic        in_decrypt,
  output logic [0:63] core_block_in,
  output logic [1:0]  core_key_sel,
  output logic        core_key_decrypt,
  input  logic [0:63] core_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] out_block,
  output logic        busy
);

  localparam int unsigned BLK_W  = 64;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PASS_W = 2;
  localparam logic [CNT_W-1:0]  CAPTURE_CNT = CNT_W'(CORE_LATENCY);
  localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state, w_state;
  logic [PASS_W-1:0]   r_pass, w_pass;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic                r_decrypt, w_decrypt;
  logic [0:BLK_W-1]    r_block_in, w_block_in;
  logic [1:0]          r_key_sel, w_key_sel;
  logic                r_key_dec, w_key_dec;
  logic                r_out_valid, w_out_valid;
  logic [0:BLK_W-1]    r_out_block, w_out_block;

  // Key order: encrypt K1,K2,K3; decrypt K3,K2,K1.
  function automatic logic [1:0] key_sel_f(input logic dec, input logic [PASS_W-1:0] pass);
    return dec ? 2'(2'd2 - pass) : pass;
  endfunction

  // Direction alternates per pass: encrypt E,D,E; decrypt D,E,D.
  function automatic logic key_dec_f(input logic dec, input logic [PASS_W-1:0] pass);
    return dec ^ pass[0];
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pass      <= '0;
      r_cnt       <= '0;
      r_decrypt   <= 1'b0;
      r_block_in  <= '0;
      r_key_sel   <= '0;
      r_key_dec   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_block <= '0;
    end else begin
      r_state     <= w_state;
      r_pass      <= w_pass;
      r_cnt       <= w_cnt;
      r_decrypt   <= w_decrypt;
      r_block_in  <= w_block_in;
      r_key_sel   <= w_key_sel;
      r_key_dec   <= w_key_dec;
      r_out_valid <= w_out_valid;
      r_out_block <= w_out_block;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    w_state     = r_state;
    w_pass      = r_pass;
    w_cnt       = r_cnt;
    w_decrypt   = r_decrypt;
    w_block_in  = r_block_in;
    w_key_sel   = r_key_sel;
    w_key_dec   = r_key_dec;
    w_out_valid = r_out_valid;
    w_out_block = r_out_block;
    unique case (r_state)
      S_IDLE: begin
        // in_ready is high in IDLE, so in_valid alone completes the handshake
        if (in_valid) begin
          w_state    = S_RUN;
          w_block_in = in_block;
          w_decrypt  = in_decrypt;
          w_pass     = '0;
          w_cnt      = '0;
          w_key_sel  = key_sel_f(in_decrypt, '0);
          w_key_dec  = key_dec_f(in_decrypt, '0);
        end
      end
      S_RUN: begin
        w_cnt = r_cnt + CNT_W'(1);
        if (r_cnt == CAPTURE_CNT) begin
          if (r_pass == LAST_PASS) begin
            w_out_block = core_out;
            w_out_valid = 1'b1;
            w_state     = S_DONE;
          end else begin
            // Feed the result back and switch keys on the same edge
            w_block_in = core_out;
            w_pass     = r_pass + PASS_W'(1);
            w_cnt      = '0;
            w_key_sel  = key_sel_f(r_decrypt, r_pass + PASS_W'(1));
            w_key_dec  = key_dec_f(r_decrypt, r_pass + PASS_W'(1));
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid = 1'b0;
          w_state     = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign in_ready         = (r_state == S_IDLE);
  assign busy             = (r_state != S_IDLE);
  assign core_block_in    = r_block_in;
  assign core_key_sel     = r_key_sel;
  assign core_key_decrypt = r_key_dec;
  assign out_valid        = r_out_valid;
  assign out_block        = r_out_block;

endmodule

// File: tb/tb_des_3des_sequencer.sv
// Testbench for des_3des_sequencer: a toy invertible block cipher stands in
// for the pipelined DES core; results are compared with a 3DES EDE model.
module tb_des_3des_sequencer;

  localparam int LAT      = 16;
  localparam int PASS_CYC = LAT + 1;
  localparam int RUN_CYC  = 3 * PASS_CYC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [0:63] in_block = '0;
  logic        in_decrypt = 1'b0;
  logic [0:63] core_block_in;
  logic [1:0]  core_key_sel;
  logic        core_key_decrypt;
  logic [0:63] core_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [0:63] out_block;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_acc   = 0;
  int last_hs = 0;

  logic [0:63] keys [4];
  logic [0:63] pipe [LAT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  des_3des_sequencer #(.CORE_LATENCY(LAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_block         (in_block),
    .in_decrypt       (in_decrypt),
    .core_block_in    (core_block_in),
    .core_key_sel     (core_key_sel),
    .core_key_decrypt (core_key_decrypt),
    .core_out         (core_out),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_block        (out_block),
    .busy             (busy)
  );

  // Toy single-block cipher: E(x) = rotl1(x) ^ k, D is its inverse
  function automatic logic [0:63] enc1(input logic [0:63] x, input logic [0:63] k);
    return {x[1:63], x[0]} ^ k;
  endfunction

  function automatic logic [0:63] dec1(input logic [0:63] y, input logic [0:63] k);
    logic [0:63] t;
    t = y ^ k;
    return {t[63], t[0:62]};
  endfunction

  function automatic logic [0:63] core_fn(input logic [0:63] x, input logic [1:0] sel, input logic d);
    return d ? dec1(x, keys[sel]) : enc1(x, keys[sel]);
  endfunction

  // Pipelined core model: output reflects inputs from LAT edges earlier
  always @(posedge clk) begin
    pipe[0] <= core_fn(core_block_in, core_key_sel, core_key_decrypt);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"},  64'(in_ready), 64'(1));
    chk({tag, " busy"},      64'(busy), 64'(0));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, " out_block"}, 64'(out_block), 64'(0));
    chk({tag, " core_in"},   64'(core_block_in), 64'(0));
    chk({tag, " key_sel"},   64'(core_key_sel), 64'(0));
    chk({tag, " key_dec"},   64'(core_key_decrypt), 64'(0));
  endtask

  // Offers x, checks every cycle of the three passes, holds the result for
  // `hold` cycles (offering nx meanwhile), then completes the handshake.
  // Entered and left just after a falling edge.
  task automatic run_block(input logic [0:63] x, input logic dec, input int hold,
                           input logic [0:63] nx, input logic ndec,
                           output logic [0:63] res);
    logic [0:63] s [4];
    logic [1:0]  ks [3];
    logic        kd [3];
    int          n;
    int          p;
    s[0] = x;
    if (!dec) begin
      s[1] = enc1(s[0], keys[0]); s[2] = dec1(s[1], keys[1]); s[3] = enc1(s[2], keys[2]);
      ks[0] = 2'd0; ks[1] = 2'd1; ks[2] = 2'd2;
      kd[0] = 1'b0; kd[1] = 1'b1; kd[2] = 1'b0;
    end else begin
      s[1] = dec1(s[0], keys[2]); s[2] = enc1(s[1], keys[1]); s[3] = dec1(s[2], keys[0]);
      ks[0] = 2'd2; ks[1] = 2'd1; ks[2] = 2'd0;
      kd[0] = 1'b1; kd[1] = 1'b0; kd[2] = 1'b1;
    end
    res = '0;
    in_valid = 1'b1; in_block = x; in_decrypt = dec;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    t_acc = cyc;
    // Keep offering the next block; it must not be taken while busy
    in_block = nx; in_decrypt = ndec;
    for (int j = 0; j < RUN_CYC; j++) begin
      p = j / PASS_CYC;
      chk("core_block_in", 64'(core_block_in), 64'(s[p]));
      chk("core_key_sel",  64'(core_key_sel), 64'(ks[p]));
      chk("core_key_dec",  64'(core_key_decrypt), 64'(kd[p]));
      chk("early_valid",   64'(out_valid), 64'(0));
      chk("run_ready",     64'({in_ready, busy}), 64'(2'b01));
      @(negedge clk);
    end
    chk("out_valid_rise", 64'(out_valid), 64'(1));
    chk("out_block",      64'(out_block), 64'(s[3]));
    out_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_block", 64'(out_block), 64'(s[3]));
      chk("bp_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    last_hs = cyc;
    out_ready = 1'b0;
    chk("hs_valid_low", 64'(out_valid), 64'(0));
    chk("hs_idle",      64'({in_ready, busy}), 64'(2'b10));
    chk("hs_retain",    64'(out_block), 64'(s[3]));
    res = out_block;
  endtask

  task automatic rand_keys();
    for (int i = 0; i < 4; i++) keys[i] = {$urandom(), $urandom()};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:63] x, y, r, r2, nx;
    int          hs_prev, acc_prev;
    rand_keys();
    #1;
    chk_reset_vals("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single-DES equivalence: equal keys collapse EDE to one encryption
    keys[1] = keys[0]; keys[2] = keys[0];
    x = {$urandom(), $urandom()};
    run_block(x, 1'b0, 0, '0, 1'b0, r);
    chk("single_equiv", 64'(r), 64'(enc1(x, keys[0])));

    // Decrypt round trip with distinct keys
    rand_keys();
    x = {$urandom(), $urandom()};
    run_block(x, 1'b0, 0, '0, 1'b0, y);
    run_block(y, 1'b1, 0, '0, 1'b0, r);
    chk("round_trip", 64'(r), 64'(x));

    // Back-pressure with a second block waiting
    x  = {$urandom(), $urandom()};
    nx = {$urandom(), $urandom()};
    run_block(x, 1'b0, 20, nx, 1'b1, r);
    hs_prev = last_hs;
    run_block(nx, 1'b1, 0, '0, 1'b0, r2);
    chk("accept_after_hs", 64'(t_acc - hs_prev), 64'(1));
    in_valid = 1'b0;

    // Reset at cnt = 5 of pass 1
    x = {$urandom(), $urandom()};
    in_valid = 1'b1; in_block = x; in_decrypt = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (PASS_CYC + 5) @(negedge clk);
    chk("pre_abort_busy", 64'(busy), 64'(1));
    #1 rst = 1'b1;
    #1 chk_reset_vals("async_reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < RUN_CYC + 10; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(out_valid), 64'(0));
    end
    x = {$urandom(), $urandom()};
    run_block(x, 1'b1, 0, '0, 1'b0, r);

    // Back-to-back streaming of four blocks
    rand_keys();
    acc_prev = 0;
    for (int b = 0; b < 4; b++) begin
      x  = {$urandom(), $urandom()};
      nx = {$urandom(), $urandom()};
      run_block(x, 1'($urandom_range(0, 1)), 0, nx, 1'b0, r);
      if (b > 0) chk("stream_gap", 64'(t_acc - acc_prev), 64'(RUN_CYC + 2));
      acc_prev = t_acc;
    end
    in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
